// File: rtl/spi_write_sequencer_if.sv
// Command bus between the write sequencer and the SPI write master.
// The sequencer drives one frame at a time and the master answers with a done pulse.
interface spi_write_sequencer_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int RATIO_W   = 8
);
  logic                 spi_start;
  logic [ADDR_BITS-1:0] spi_address;
  logic [DATA_BITS-1:0] spi_data;
  logic [RATIO_W-1:0]   spi_ratio;
  logic                 spi_done;

  modport master (
    output spi_start,
    output spi_address,
    output spi_data,
    output spi_ratio,
    input  spi_done
  );

  modport slave (
    input  spi_start,
    input  spi_address,
    input  spi_data,
    input  spi_ratio,
    output spi_done
  );
endinterface

// File: rtl/spi_write_sequencer.sv
// Queues {address,data} register writes and issues them one at a time to the SPI write master.
// Define SPI_SEQ_TIMEOUT_EN to add a watchdog that abandons a frame and raises sticky timeout_err.
module spi_write_sequencer #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 8,
  parameter int RATIO_W   = 8,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic [RATIO_W-1:0]     cfg_ratio,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   seq_busy,
  spi_write_sequencer_if.master  spi
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("spi_write_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t               state;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [ADDR_BITS-1:0] addr_mem [DEPTH];
  logic [DATA_BITS-1:0] data_mem [DEPTH];
  logic                 push;
  logic                 pop;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] wait_cnt;
`endif

  assign full     = (level == FULL_LEVEL);
  assign empty    = (level == '0);
  assign push     = wr_en && !full;
  assign pop      = (state == S_IDLE) && !empty;
  assign seq_busy = (state != S_IDLE) || !empty;

  // Storage has no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      level           <= '0;
      overflow        <= 1'b0;
      spi.spi_start   <= 1'b0;
      spi.spi_address <= '0;
      spi.spi_data    <= '0;
      spi.spi_ratio   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LEVEL_ONE;
      end else if (pop && !push) begin
        level <= level - LEVEL_ONE;
      end

      spi.spi_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // The head leaves the queue at launch; the master holds these until done.
          if (!empty) begin
            spi.spi_address <= addr_mem[rd_ptr];
            spi.spi_data    <= data_mem[rd_ptr];
            spi.spi_ratio   <= cfg_ratio;
            spi.spi_start   <= 1'b1;
            state           <= S_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (spi.spi_done) begin
            state <= S_IDLE;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_ONE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Directed bench for spi_write_sequencer: reset, single write, burst, overflow, reset mid-frame, pointer wrap.
// Also exercises the watchdog when built with SPI_SEQ_TIMEOUT_EN.
module tb_spi_write_sequencer;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam int RATIO_W   = 8;
  localparam int DEPTH     = 8;
  localparam int TIMEOUT   = 16;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  cfg_ratio;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;
  logic        seq_busy;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  spi_write_sequencer_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .RATIO_W(RATIO_W)) spi_bus ();

  spi_write_sequencer #(
    .DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS), .RATIO_W(RATIO_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cfg_ratio(cfg_ratio),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .seq_busy(seq_busy),
    .spi(spi_bus)
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] wrap_addr(input int i);
    return 8'(8'h80 + i);
  endfunction

  function automatic logic [15:0] wrap_data(input int i);
    return 16'(16'hC000 + i * 3);
  endfunction

  // Inputs change and outputs are observed on the falling edge, half a cycle from the DUT's edge.
  task automatic test_reset;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cfg_ratio = 8'd8; spi_bus.spi_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (spi_bus.spi_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start: got %b expected 0", spi_bus.spi_start); end
    vectors++; if (spi_bus.spi_address !== 8'h00 || spi_bus.spi_data !== 16'h0000 || spi_bus.spi_ratio !== 8'h00) begin
      miscompares++; $display("[TB] FAIL reset_bus: got %h/%h/%h expected 00/0000/00", spi_bus.spi_address, spi_bus.spi_data, spi_bus.spi_ratio);
    end
    vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", seq_busy); end
`ifdef SPI_SEQ_TIMEOUT_EN
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
`endif
  endtask

  task automatic test_single_write;
    cfg_ratio = 8'd8;
    wr_en = 1'b1; wr_addr = 8'h3A; wr_data = 16'hBEEF;
    @(negedge clk);
    wr_en = 1'b0;
    vectors++; if (level !== 4'd1) begin miscompares++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    vectors++; if (spi_bus.spi_start !== 1'b0) begin miscompares++; $display("[TB] FAIL single_start_early: got %b expected 0", spi_bus.spi_start); end
    vectors++; if (seq_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_queued: got %b expected 1", seq_busy); end
    @(negedge clk);
    vectors++; if (spi_bus.spi_start !== 1'b1) begin miscompares++; $display("[TB] FAIL single_start: got %b expected 1", spi_bus.spi_start); end
    vectors++; if (spi_bus.spi_address !== 8'h3A || spi_bus.spi_data !== 16'hBEEF || spi_bus.spi_ratio !== 8'd8) begin
      miscompares++; $display("[TB] FAIL single_frame: got %h/%h/%0d expected 3a/beef/8", spi_bus.spi_address, spi_bus.spi_data, spi_bus.spi_ratio);
    end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("[TB] FAIL single_level_pop: got %0d expected 0", level); end
    @(negedge clk);
    vectors++; if (spi_bus.spi_start !== 1'b0) begin miscompares++; $display("[TB] FAIL single_start_width: got %b expected 0", spi_bus.spi_start); end
    vectors++; if (seq_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_wait: got %b expected 1", seq_busy); end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_done: got %b expected 0", seq_busy); end
  endtask

  task automatic test_burst;
    logic [7:0]  exp_addr [2];
    logic [15:0] exp_data [2];
    logic [3:0]  exp_level [2];
    exp_addr = '{8'hA2, 8'hA3}; exp_data = '{16'h2222, 16'h3333}; exp_level = '{4'd1, 4'd0};
    wr_en = 1'b1; wr_addr = 8'hA1; wr_data = 16'h1111;
    @(negedge clk);
    wr_addr = 8'hA2; wr_data = 16'h2222;
    vectors++; if (spi_bus.spi_start !== 1'b0 || level !== 4'd1) begin
      miscompares++; $display("[TB] FAIL burst_first_push: got start=%b level=%0d expected start=0 level=1", spi_bus.spi_start, level);
    end
    @(negedge clk);
    wr_addr = 8'hA3; wr_data = 16'h3333;
    vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== 8'hA1 || spi_bus.spi_data !== 16'h1111) begin
      miscompares++; $display("[TB] FAIL burst_frame0: got start=%b %h/%h expected start=1 a1/1111", spi_bus.spi_start, spi_bus.spi_address, spi_bus.spi_data);
    end
    vectors++; if (level !== 4'd1) begin miscompares++; $display("[TB] FAIL burst_push_pop_level: got %0d expected 1", level); end
    @(negedge clk);
    wr_en = 1'b0;
    vectors++; if (spi_bus.spi_start !== 1'b0 || level !== 4'd2) begin
      miscompares++; $display("[TB] FAIL burst_queued: got start=%b level=%0d expected start=0 level=2", spi_bus.spi_start, level);
    end
    for (int j = 0; j < 2; j++) begin
      spi_bus.spi_done = 1'b1;
      @(negedge clk);
      spi_bus.spi_done = 1'b0;
      vectors++; if (spi_bus.spi_start !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_gap%0d: got start=%b expected 0", j + 1, spi_bus.spi_start); end
      @(negedge clk);
      vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== exp_addr[j] || spi_bus.spi_data !== exp_data[j] || level !== exp_level[j]) begin
        miscompares++; $display("[TB] FAIL burst_frame%0d: got start=%b %h/%h level=%0d expected start=1 %h/%h level=%0d",
          j + 1, spi_bus.spi_start, spi_bus.spi_address, spi_bus.spi_data, level, exp_addr[j], exp_data[j], exp_level[j]);
      end
    end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    vectors++; if (seq_busy !== 1'b0 || empty !== 1'b1) begin
      miscompares++; $display("[TB] FAIL burst_drained: got busy=%b empty=%b expected busy=0 empty=1", seq_busy, empty);
    end
  endtask

  task automatic test_full_overflow;
    cfg_ratio = 8'd3;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_addr = 8'(8'h10 + i); wr_data = 16'(16'h5000 + i);
      @(negedge clk);
    end
    vectors++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ovf_filled: got full=%b level=%0d ovf=%b expected full=1 level=8 ovf=0", full, level, overflow);
    end
    vectors++; if (spi_bus.spi_address !== 8'h10 || spi_bus.spi_ratio !== 8'd3) begin
      miscompares++; $display("[TB] FAIL ovf_frame0: got %h ratio %0d expected 10 ratio 3", spi_bus.spi_address, spi_bus.spi_ratio);
    end
    wr_addr = 8'h19; wr_data = 16'h5009;
    @(negedge clk);
    wr_en = 1'b0;
    cfg_ratio = 8'd8;
    vectors++; if (overflow !== 1'b1 || level !== 4'd8 || full !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ovf_dropped: got ovf=%b level=%0d full=%b expected ovf=1 level=8 full=1", overflow, level, full);
    end
    for (int i = 1; i < 9; i++) begin
      spi_bus.spi_done = 1'b1;
      @(negedge clk);
      spi_bus.spi_done = 1'b0;
      @(negedge clk);
      vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== 8'(8'h10 + i) || spi_bus.spi_data !== 16'(16'h5000 + i)) begin
        miscompares++; $display("[TB] FAIL ovf_drain%0d: got start=%b %h/%h expected start=1 %h/%h",
          i, spi_bus.spi_start, spi_bus.spi_address, spi_bus.spi_data, 8'(8'h10 + i), 16'(16'h5000 + i));
      end
    end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    @(negedge clk);
    vectors++; if (seq_busy !== 1'b0 || empty !== 1'b1 || spi_bus.spi_start !== 1'b0 || overflow !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ovf_end: got busy=%b empty=%b start=%b ovf=%b expected 0/1/0/1", seq_busy, empty, spi_bus.spi_start, overflow);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = 8'(8'h60 + i); wr_data = 16'(16'h6000 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    vectors++; if (level !== 4'd5 || seq_busy !== 1'b1 || overflow !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rstmid_setup: got level=%0d busy=%b ovf=%b expected 5/1/1", level, seq_busy, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_queue: got empty=%b level=%0d full=%b expected 1/0/0", empty, level, full);
    end
    vectors++; if (spi_bus.spi_start !== 1'b0 || overflow !== 1'b0 || seq_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_flags: got start=%b ovf=%b busy=%b expected 0/0/0", spi_bus.spi_start, overflow, seq_busy);
    end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    @(negedge clk);
    vectors++; if (spi_bus.spi_start !== 1'b0 || seq_busy !== 1'b0 || level !== 4'd0) begin
      miscompares++; $display("[TB] FAIL idle_done_ignored: got start=%b busy=%b level=%0d expected 0/0/0", spi_bus.spi_start, seq_busy, level);
    end
  endtask

  task automatic test_wrap;
    wr_en = 1'b1; wr_addr = wrap_addr(0); wr_data = wrap_data(0);
    @(negedge clk);
    wr_addr = wrap_addr(1); wr_data = wrap_data(1);
    @(negedge clk);
    wr_en = 1'b0;
    vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== wrap_addr(0) || level !== 4'd1) begin
      miscompares++; $display("[TB] FAIL wrap_frame0: got start=%b %h level=%0d expected start=1 %h level=1", spi_bus.spi_start, spi_bus.spi_address, level, wrap_addr(0));
    end
    for (int i = 1; i < 19; i++) begin
      spi_bus.spi_done = 1'b1;
      @(negedge clk);
      spi_bus.spi_done = 1'b0;
      wr_en = 1'b1; wr_addr = wrap_addr(i + 1); wr_data = wrap_data(i + 1);
      @(negedge clk);
      wr_en = 1'b0;
      vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== wrap_addr(i) || spi_bus.spi_data !== wrap_data(i) || level !== 4'd1) begin
        miscompares++; $display("[TB] FAIL wrap_frame%0d: got start=%b %h/%h level=%0d expected start=1 %h/%h level=1",
          i, spi_bus.spi_start, spi_bus.spi_address, spi_bus.spi_data, level, wrap_addr(i), wrap_data(i));
      end
    end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    @(negedge clk);
    vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== wrap_addr(19) || spi_bus.spi_data !== wrap_data(19) || level !== 4'd0) begin
      miscompares++; $display("[TB] FAIL wrap_frame19: got start=%b %h/%h level=%0d expected start=1 %h/%h level=0",
        spi_bus.spi_start, spi_bus.spi_address, spi_bus.spi_data, level, wrap_addr(19), wrap_data(19));
    end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_end_busy: got %b expected 0", seq_busy); end
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    wr_en = 1'b1; wr_addr = 8'hA0; wr_data = 16'hAAAA;
    @(negedge clk);
    wr_addr = 8'hB0; wr_data = 16'hBBBB;
    @(negedge clk);
    wr_en = 1'b0;
    vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== 8'hA0) begin
      miscompares++; $display("[TB] FAIL to_launch: got start=%b %h expected start=1 a0", spi_bus.spi_start, spi_bus.spi_address);
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    vectors++; if (timeout_err !== 1'b0 || spi_bus.spi_start !== 1'b0) begin
      miscompares++; $display("[TB] FAIL to_early: got err=%b start=%b expected 0/0", timeout_err, spi_bus.spi_start);
    end
    @(negedge clk);
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err: got %b expected 1", timeout_err); end
    @(negedge clk);
    vectors++; if (spi_bus.spi_start !== 1'b1 || spi_bus.spi_address !== 8'hB0 || spi_bus.spi_data !== 16'hBBBB || level !== 4'd0) begin
      miscompares++; $display("[TB] FAIL to_next: got start=%b %h/%h level=%0d expected start=1 b0/bbbb level=0",
        spi_bus.spi_start, spi_bus.spi_address, spi_bus.spi_data, level);
    end
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    spi_bus.spi_done = 1'b0;
    vectors++; if (seq_busy !== 1'b0 || timeout_err !== 1'b1) begin
      miscompares++; $display("[TB] FAIL to_end: got busy=%b err=%b expected 0/1", seq_busy, timeout_err);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting spi_write_sequencer bench");
    test_reset();
    test_single_write();
    test_burst();
    test_full_overflow();
    test_reset_mid();
    test_wrap();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
